pss_search_ctrl: RTL
====================

# pss_search_ctrl

Sequencing controller for the PSS detector in the SSB receive chain. It starts the detector in full search, locks onto the first detected N_id_2, and then opens a narrow track window around each expected PSS position, one SSB period later. It counts missed PSS occurrences and falls back to search after a configurable number of consecutive misses. It sits beside the PSS detector, driving its mode and requested-N_id_2 inputs from the decimated (CIC output) sample strobe.

## Interface
- SSB_PERIOD, 38400: expected PSS-to-PSS spacing in decimated samples; must be > WINDOW_LEN.
- WINDOW_LEN, 8: track window width in samples; even; window is centred on the expected peak.
- MAX_MISSES, 3: consecutive misses that drop lock; range 1..15.
- CNT_DW (local): $clog2(SSB_PERIOD + WINDOW_LEN + 1).

Ports:
- clk_i  in  1  single clock for all logic.
- reset_i  in  1  synchronous, active-high reset.
- s_axis_in_tvalid  in  1  decimated sample strobe; the counter advances only on this strobe.
- N_id_2_valid_i  in  1  single-cycle detection pulse from the PSS detector.
- N_id_2_i  in  2  detected N_id_2; values 0..2; valid with the pulse.
- mode_o  out  2  detector mode: 0 SEARCH (all ids), 1 TRACK (requested id only), 2 PAUSE (detection suppressed).
- requested_N_id_2_o  out  2  id the detector must track.
- locked_o  out  1  lock status.
- window_o  out  1  high while the track window is open.
- miss_cnt_o  out  4  current count of consecutive misses.
- lock_lost_o  out  1  one-cycle pulse when lock is dropped.

## Operation
- States: SEARCH, WAIT, WINDOW, plus CONFIRM (macro only). Sample counter `cnt` has width CNT_DW.
- SEARCH: mode_o=0, locked_o=0, `cnt` held at 0.
  - On N_id_2_valid_i with N_id_2_i ≤ 2: latch requested_N_id_2_o, set `cnt`=0, set miss_cnt_o=0, go to WAIT. Set locked_o=1, or go to CONFIRM if the macro is enabled.
  - N_id_2_i=3 is ignored in every state.
- WAIT: mode_o=2.
  - `cnt` increments on each strobe.
  - When `cnt` reaches SSB_PERIOD−WINDOW_LEN/2 on a strobe: go to WINDOW, window_o=1.
  - Detections are ignored.
- WINDOW: mode_o=1; `cnt` keeps incrementing.
  - Detection whose N_id_2_i equals requested_N_id_2_o:
    - set `cnt`=0 (re-anchor to the actual peak);
    - set miss_cnt_o=0;
    - go to WAIT.
  - A mismatched id is ignored.
  - When `cnt` reaches SSB_PERIOD+WINDOW_LEN/2 on a strobe without a detection (a miss):
    - increment miss_cnt_o;
    - set `cnt`=WINDOW_LEN/2 (re-anchor to the nominal peak);
    - go to WAIT.
  - If the incremented miss count equals MAX_MISSES: instead go to SEARCH, set locked_o=0, miss_cnt_o=0, and pulse lock_lost_o.
- Simultaneous matching detection and window-close strobe: the detection wins and no miss is counted.
- Detection and strobe in the same cycle: `cnt` is set to 0; the strobe is not counted.
- reset_i in any state, including mid-window, returns to SEARCH with outputs at their reset values in the next cycle.

## Timing
- All outputs are registered and change in the cycle after the causing event.
- Reset values:
  - mode_o=0;
  - requested_N_id_2_o=0;
  - locked_o=0;
  - window_o=0;
  - miss_cnt_o=0;
  - lock_lost_o=0.
- window_o is 1 exactly when the state is WINDOW. The window spans WINDOW_LEN strobes: from `cnt`=SSB_PERIOD−WINDOW_LEN/2 up to SSB_PERIOD+WINDOW_LEN/2.
- No backpressure: every input is consumed in the cycle it is presented, and no ready signal exists.

## Configuration
- PSS_SEARCH_CTRL_CONFIRM_EN defined:
  - The first detection enters CONFIRM, which uses mode_o=1 and the WAIT/WINDOW timing, with locked_o=0.
  - A matching detection inside the first window sets locked_o=1 and goes to WAIT.
  - A miss or a mismatch-only window returns to SEARCH without a lock_lost_o pulse.
- PSS_SEARCH_CTRL_CONFIRM_EN undefined: the CONFIRM state is absent, and locked_o=1 on the first detection.

## Test plan
All scenarios use SSB_PERIOD=64, WINDOW_LEN=8, MAX_MISSES=2, with a continuous strobe unless noted.
- Acquisition:
  - Stimulus: detection with id 1 in SEARCH.
  - Response: requested_N_id_2_o=1, locked_o=1, mode_o=2 next cycle; window_o rises after strobe 60 and mode_o=1.
- Tracking:
  - Stimulus: matching detection at `cnt`=63.
  - Response: window_o falls, miss_cnt_o=0; the next window opens after a further 60 strobes.
- Loss:
  - Stimulus: no detections after lock.
  - Response: miss_cnt_o=1 after strobe 68; after the second window close, lock_lost_o pulses for 1 cycle, locked_o=0, mode_o=0.
- Mismatch and tie:
  - Stimulus: id 2 detected inside a window locked on id 1.
  - Response: the detection is ignored and a miss is counted.
  - Stimulus: a matching detection coincident with the close strobe at `cnt`=68.
  - Response: miss_cnt_o stays 0.
- Strobe gating and reset:
  - Stimulus: strobe driven every 4th cycle.
  - Response: window timing scales by ×4.
  - Stimulus: reset_i asserted mid-window.
  - Response: all outputs at reset values the next cycle.
- Confirm (macro defined):
  - Stimulus: first detection.
  - Response: locked_o=0, mode_o=1.
  - Stimulus: matching detection in the first window.
  - Response: locked_o=1.
  - Stimulus: no detection in the first window.
  - Response: SEARCH, with no lock_lost_o pulse.

Source files
------------

// File: rtl/pss_search_ctrl.sv
// PSS search/track sequencer: acquires an N_id_2, then opens a narrow track window
// once per SSB period. Optional confirm stage enabled by PSS_SEARCH_CTRL_CONFIRM_EN.
module pss_search_ctrl #(
    parameter int SSB_PERIOD = 38400,
    parameter int WINDOW_LEN = 8,
    parameter int MAX_MISSES = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       s_axis_in_tvalid,
    input  logic       N_id_2_valid_i,
    input  logic [1:0] N_id_2_i,
    output logic [1:0] mode_o,
    output logic [1:0] requested_N_id_2_o,
    output logic       locked_o,
    output logic       window_o,
    output logic [3:0] miss_cnt_o,
    output logic       lock_lost_o
);

    localparam int CNT_DW = $clog2(SSB_PERIOD + WINDOW_LEN + 1);
    localparam logic [CNT_DW-1:0] OPEN_AT  = CNT_DW'(SSB_PERIOD - WINDOW_LEN / 2);
    localparam logic [CNT_DW-1:0] CLOSE_AT = CNT_DW'(SSB_PERIOD + WINDOW_LEN / 2);
    localparam logic [CNT_DW-1:0] HALF_WIN = CNT_DW'(WINDOW_LEN / 2);
    localparam logic [CNT_DW-1:0] CNT_ZERO = {CNT_DW{1'b0}};
    localparam logic [CNT_DW-1:0] CNT_ONE  = {{(CNT_DW-1){1'b0}}, 1'b1};
    localparam logic [3:0]        MAX_MISS = 4'(MAX_MISSES);

    localparam logic [1:0] MODE_SEARCH = 2'd0;
    localparam logic [1:0] MODE_TRACK  = 2'd1;
    localparam logic [1:0] MODE_PAUSE  = 2'd2;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_WAIT    = 2'd1,
        ST_WINDOW  = 2'd2
`ifdef PSS_SEARCH_CTRL_CONFIRM_EN
        ,ST_CONFIRM = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [CNT_DW-1:0] cnt;
    logic [CNT_DW-1:0] cnt_inc;
    logic [3:0]        miss_inc;
    logic              det;
    logic              match;

    assign cnt_inc  = cnt + CNT_ONE;
    assign miss_inc = miss_cnt_o + 4'd1;
    // id 3 is not a legal N_id_2 and never counts as a detection
    assign det      = N_id_2_valid_i && (N_id_2_i != 2'd3);
    assign match    = det && (N_id_2_i == requested_N_id_2_o);

    // Sequencer state, sample counter and all registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state              <= ST_SEARCH;
            cnt                <= CNT_ZERO;
            mode_o             <= MODE_SEARCH;
            requested_N_id_2_o <= 2'd0;
            locked_o           <= 1'b0;
            window_o           <= 1'b0;
            miss_cnt_o         <= 4'd0;
            lock_lost_o        <= 1'b0;
        end else begin
            lock_lost_o <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    cnt <= CNT_ZERO;
                    if (det) begin
                        requested_N_id_2_o <= N_id_2_i;
                        miss_cnt_o         <= 4'd0;
`ifdef PSS_SEARCH_CTRL_CONFIRM_EN
                        state              <= ST_CONFIRM;
                        mode_o             <= MODE_TRACK;
                        locked_o           <= 1'b0;
`else
                        state              <= ST_WAIT;
                        mode_o             <= MODE_PAUSE;
                        locked_o           <= 1'b1;
`endif
                    end
                end
                ST_WAIT: begin
                    if (s_axis_in_tvalid) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == OPEN_AT) begin
                            state    <= ST_WINDOW;
                            mode_o   <= MODE_TRACK;
                            window_o <= 1'b1;
                        end
                    end
                end
                ST_WINDOW: begin
                    // a matching peak re-anchors the counter and beats a coincident close strobe
                    if (match) begin
                        cnt        <= CNT_ZERO;
                        miss_cnt_o <= 4'd0;
                        state      <= ST_WAIT;
                        mode_o     <= MODE_PAUSE;
                        window_o   <= 1'b0;
                    end else if (s_axis_in_tvalid) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CLOSE_AT) begin
                            window_o <= 1'b0;
                            if (miss_inc == MAX_MISS) begin
                                state       <= ST_SEARCH;
                                cnt         <= CNT_ZERO;
                                mode_o      <= MODE_SEARCH;
                                locked_o    <= 1'b0;
                                miss_cnt_o  <= 4'd0;
                                lock_lost_o <= 1'b1;
                            end else begin
                                state      <= ST_WAIT;
                                cnt        <= HALF_WIN;
                                mode_o     <= MODE_PAUSE;
                                miss_cnt_o <= miss_inc;
                            end
                        end
                    end
                end
`ifdef PSS_SEARCH_CTRL_CONFIRM_EN
                ST_CONFIRM: begin
                    // only a matching peak inside the first window confirms the lock
                    if (match && (cnt >= OPEN_AT)) begin
                        cnt      <= CNT_ZERO;
                        state    <= ST_WAIT;
                        mode_o   <= MODE_PAUSE;
                        locked_o <= 1'b1;
                    end else if (s_axis_in_tvalid) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CLOSE_AT) begin
                            state  <= ST_SEARCH;
                            cnt    <= CNT_ZERO;
                            mode_o <= MODE_SEARCH;
                        end
                    end
                end
`endif
                default: begin
                    state      <= ST_SEARCH;
                    cnt        <= CNT_ZERO;
                    mode_o     <= MODE_SEARCH;
                    locked_o   <= 1'b0;
                    window_o   <= 1'b0;
                    miss_cnt_o <= 4'd0;
                end
            endcase
        end
    end

endmodule
